// File: rtl/ofdm_rx_demux.sv
// OFDM receive demultiplexer: splits FFT output bins into null, pilot and data
// carriers; pilots go out as strobes, data carriers through a show-ahead FIFO.
module ofdm_rx_demux #(
  parameter int N_FFT      = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sop_in,
  input  logic               valid_in,
  input  logic signed [15:0] real_in,
  input  logic signed [15:0] imag_in,
  input  logic               ready_in,
  output logic signed [15:0] data_i,
  output logic signed [15:0] data_q,
  output logic               valid_data,
  output logic signed [15:0] pilot_i,
  output logic signed [15:0] pilot_q,
  output logic               valid_pilot,
  output logic [5:0]         index_pilot,
  output logic               sign_pilot,
  output logic               eos,
  output logic               sync_err,
  output logic               ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] LAST_BIN = 10'(N_FFT - 1);

  typedef enum logic {IDLE, SYMBOL} state_t;

  state_t      state, state_next;
  logic [9:0]  bin_cnt, bin_cnt_next, cur_bin;
  logic [5:0]  pilot_ord, pilot_ord_next;
  logic        accept, resync, last_bin, is_null, is_pilot, is_data;

  logic               st_pilot, st_data, st_eos, st_sync;
  logic signed [15:0] st_i, st_q;
  logic [5:0]         st_ord;

  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push, drop;
  logic [31:0] head;

  // A sop always restarts numbering at bin 0, whether from IDLE or as a resync.
  always_comb begin
    state_next     = state;
    bin_cnt_next   = bin_cnt;
    pilot_ord_next = pilot_ord;
    accept   = valid_in & (sop_in | (state == SYMBOL));
    resync   = valid_in & sop_in & (state == SYMBOL) & (bin_cnt != 10'd0);
    cur_bin  = (sop_in || state == IDLE) ? 10'd0 : bin_cnt;
    last_bin = accept & ~sop_in & (cur_bin == LAST_BIN);
    is_null  = (cur_bin == 10'd0) || (cur_bin >= 10'd401 && cur_bin <= 10'd623);
    is_pilot = ~is_null & (cur_bin[3:0] == 4'd8);
    is_data  = ~is_null & ~is_pilot;
    if (accept) begin
      if (sop_in) begin
        state_next     = SYMBOL;
        bin_cnt_next   = 10'd1;
        pilot_ord_next = 6'd0;
      end else if (last_bin) begin
        state_next   = IDLE;
        bin_cnt_next = 10'd0;
      end else begin
        bin_cnt_next = bin_cnt + 10'd1;
      end
      if (is_pilot) pilot_ord_next = pilot_ord + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      pilot_ord <= '0;
    end else begin
      state     <= state_next;
      bin_cnt   <= bin_cnt_next;
      pilot_ord <= pilot_ord_next;
    end
  end

  // One pipeline stage between classification and the output registers/FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_pilot <= 1'b0;
      st_data  <= 1'b0;
      st_eos   <= 1'b0;
      st_sync  <= 1'b0;
      st_i     <= '0;
      st_q     <= '0;
      st_ord   <= '0;
    end else begin
      st_pilot <= accept & is_pilot;
      st_data  <= accept & is_data;
      st_eos   <= last_bin;
      st_sync  <= resync;
      st_i     <= real_in;
      st_q     <= imag_in;
      st_ord   <= pilot_ord;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_pilot <= 1'b0;
      eos         <= 1'b0;
      sync_err    <= 1'b0;
      pilot_i     <= '0;
      pilot_q     <= '0;
      index_pilot <= '0;
      sign_pilot  <= 1'b0;
    end else begin
      valid_pilot <= st_pilot;
      eos         <= st_eos;
      sync_err    <= st_sync;
      if (st_pilot) begin
        pilot_i     <= st_i;
        pilot_q     <= st_q;
        index_pilot <= st_ord;
        sign_pilot  <= ~st_i[15];
      end
    end
  end

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & ready_in;
  assign push  = st_data & (~full | pop);
  assign drop  = st_data & full & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) ovf    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {st_i, st_q};
  end

  assign head       = empty ? 32'd0 : mem[rd_ptr[AW-1:0]];
  assign valid_data = ~empty;
  assign data_i     = head[31:16];
  assign data_q     = head[15:0];

endmodule
